// File: rtl/hud_timer_drawer.sv
// ----------------------------------------------------------------------------
// hud_timer_drawer : BCD countdown with a 3-digit scaled 3x5-font HUD readout.
// Optional macro HUD_TIMER_BLINK_EN blinks the readout in the last 10 seconds.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hud_timer_drawer #(
   parameter int          TOP_LEFT_X  = 16,
   parameter int          TOP_LEFT_Y  = 8,
   parameter logic [11:0] START_BCD   = 12'h180,
   parameter int          SCALE_SHIFT = 2,
   parameter logic [7:0]  DIGIT_COLOR = 8'hFF
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        oneSecPulse,
   input  logic        restart,
   input  logic        pause,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   output logic        timerDR,
   output logic [7:0]  timerRGB,
   output logic        timeUp,
   output logic [11:0] secondsBCD
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   localparam int          S    = 1 << SCALE_SHIFT;
   localparam logic [11:0] X_LO = 12'(TOP_LEFT_X);
   localparam logic [11:0] X_HI = 12'(TOP_LEFT_X + 12 * S);
   localparam logic [11:0] Y_LO = 12'(TOP_LEFT_Y);
   localparam logic [11:0] Y_HI = 12'(TOP_LEFT_Y + 5 * S);

   state_t      state_q, state_d;
   logic [11:0] count_q, count_d;
   logic [11:0] disp_q, disp_d;
   logic        dr_q, dr_d;
   logic [7:0]  rgb_q, rgb_d;

   logic [11:0] px, py, dx, dy;
   logic        in_region;
   logic [1:0]  digit, col;
   logic [2:0]  row;
   logic [3:0]  nibble;
   logic [2:0]  row_bits;
   logic        font_bit;
   logic        blank;

   // Only called with a value above 001, so a borrow out of tens always
   // finds a non-zero hundreds digit.
   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [3:0] h, t, u;
      h = v[11:8];
      t = v[7:4];
      u = v[3:0];
      if (u != 4'd0) begin
         u = u - 4'd1;
      end else begin
         u = 4'd9;
         if (t != 4'd0) begin
            t = t - 4'd1;
         end else begin
            t = 4'd9;
            h = h - 4'd1;
         end
      end
      return {h, t, u};
   endfunction

   function automatic logic [2:0] font_row(input logic [3:0] d, input logic [2:0] r);
      logic [14:0] g;
      case (d)
         4'd0:    g = 15'b111_101_101_101_111;
         4'd1:    g = 15'b010_110_010_010_111;
         4'd2:    g = 15'b111_001_111_100_111;
         4'd3:    g = 15'b111_001_111_001_111;
         4'd4:    g = 15'b101_101_111_001_001;
         4'd5:    g = 15'b111_100_111_001_111;
         4'd6:    g = 15'b111_100_111_101_111;
         4'd7:    g = 15'b111_001_001_001_001;
         4'd8:    g = 15'b111_101_111_101_111;
         4'd9:    g = 15'b111_101_111_001_111;
         default: g = 15'b000_000_000_000_000;
      endcase
      case (r)
         3'd0:    return g[14:12];
         3'd1:    return g[11:9];
         3'd2:    return g[8:6];
         3'd3:    return g[5:3];
         3'd4:    return g[2:0];
         default: return 3'b000;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (restart) begin
         count_d = START_BCD;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (pause) begin
                  state_d = PAUSED;
               end else if (oneSecPulse) begin
                  if (count_q == 12'h000) begin
                     state_d = EXPIRED;
                  end else if (count_q == 12'h001) begin
                     count_d = 12'h000;
                     state_d = EXPIRED;
                  end else begin
                     count_d = bcd_dec(count_q);
                  end
               end
            end
            PAUSED: begin
               if (!pause) begin
                  state_d = RUN;
               end
            end
            IDLE, EXPIRED: state_d = state_q;
            default:       state_d = IDLE;
         endcase
      end
   end

   // The latch samples the registered count, so a coincident decrement is
   // not seen until the following frame.
   always_comb begin
      disp_d = disp_q;
      if (startOfFrame) begin
         disp_d = count_q;
      end
   end

   // Bounds are compared before subtracting so wrapped offsets never hit.
   always_comb begin
      px        = {1'b0, pixelX};
      py        = {1'b0, pixelY};
      in_region = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
      dx        = px - X_LO;
      dy        = py - Y_LO;
      digit     = 2'(dx >> (SCALE_SHIFT + 2));
      col       = 2'(dx >> SCALE_SHIFT);
      row       = 3'(dy >> SCALE_SHIFT);
   end

   always_comb begin
      case (digit)
         2'd0:    nibble = disp_q[11:8];
         2'd1:    nibble = disp_q[7:4];
         default: nibble = disp_q[3:0];
      endcase
      row_bits = font_row(nibble, row);
      case (col)
         2'd0:    font_bit = row_bits[2];
         2'd1:    font_bit = row_bits[1];
         2'd2:    font_bit = row_bits[0];
         default: font_bit = 1'b0;
      endcase
   end

`ifdef HUD_TIMER_BLINK_EN
   logic [4:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (startOfFrame) begin
         frame_cnt_d = frame_cnt_q + 5'd1;
      end
   end

   // Valid BCD orders the same as unsigned binary, so a plain compare works.
   assign blank = (state_q == RUN) && (count_q <= 12'h010) && frame_cnt_q[4];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frame_cnt_q <= 5'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      dr_d  = in_region && (col != 2'd3) && font_bit && !blank;
      rgb_d = dr_d ? DIGIT_COLOR : 8'h00;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         count_q <= START_BCD;
         disp_q  <= START_BCD;
         dr_q    <= 1'b0;
         rgb_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         disp_q  <= disp_d;
         dr_q    <= dr_d;
         rgb_q   <= rgb_d;
      end
   end

   assign timerDR    = dr_q;
   assign timerRGB   = rgb_q;
   assign timeUp     = (state_q == EXPIRED);
   assign secondsBCD = count_q;

endmodule

`default_nettype wire

// File: tb/tb_hud_timer_drawer.sv
// ----------------------------------------------------------------------------
// tb_hud_timer_drawer : directed stimulus with a queued scoreboard for
// hud_timer_drawer (default preset 180 and a second instance preset to 002).
// Revision: 1.1
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hud_timer_drawer;

    logic        clk = 1'b0;
    logic        r_resetN = 1'b0;
    logic        r_sof = 1'b0;
    logic        r_sec = 1'b0;
    logic        r_restart = 1'b0;
    logic        r_pause = 1'b0;
    logic [10:0] r_px = 11'd0;
    logic [10:0] r_py = 11'd0;

    logic        w_dr1, w_dr2, w_tu1, w_tu2;
    logic [7:0]  w_rgb1, w_rgb2;
    logic [11:0] w_bcd1, w_bcd2;

    always #5 clk = ~clk;

    hud_timer_drawer dut (
        .clk(clk), .resetN(r_resetN), .startOfFrame(r_sof),
        .oneSecPulse(r_sec), .restart(r_restart), .pause(r_pause),
        .pixelX(r_px), .pixelY(r_py), .timerDR(w_dr1), .timerRGB(w_rgb1),
        .timeUp(w_tu1), .secondsBCD(w_bcd1)
    );

    hud_timer_drawer #(.START_BCD(12'h002)) dut2 (
        .clk(clk), .resetN(r_resetN), .startOfFrame(r_sof),
        .oneSecPulse(r_sec), .restart(r_restart), .pause(r_pause),
        .pixelX(r_px), .pixelY(r_py), .timerDR(w_dr2), .timerRGB(w_rgb2),
        .timeUp(w_tu2), .secondsBCD(w_bcd2)
    );

    localparam int c_SEL_BCD = 0;
    localparam int c_SEL_TU  = 1;
    localparam int c_SEL_DR  = 2;
    localparam int c_SEL_RGB = 3;

    typedef struct {
        string       name;
        int          at;
        int          inst;
        int          sel;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   r_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_sof = 0;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    exp_t        e;
    logic [11:0] act;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= r_cyc) begin
            e = exp_q.pop_front();
            case (e.sel)
                c_SEL_BCD: act = (e.inst == 0) ? w_bcd1 : w_bcd2;
                c_SEL_TU:  act = {11'd0, (e.inst == 0) ? w_tu1 : w_tu2};
                c_SEL_DR:  act = {11'd0, (e.inst == 0) ? w_dr1 : w_dr2};
                default:   act = {4'd0, (e.inst == 0) ? w_rgb1 : w_rgb2};
            endcase
            checks = checks + 1;
            if (e.at != r_cyc || act !== e.val) begin
                errors = errors + 1;
                $display("FAIL %s: got %0h expected %0h (due cycle %0d, checked %0d)",
                         e.name, act, e.val, e.at, r_cyc);
            end
        end
    end

    task automatic check_now(input string n, input logic [11:0] got,
                             input logic [11:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (immediate, cycle %0d)",
                     n, got, want, r_cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string n, input int inst, input int sel,
                              input logic [11:0] v);
        exp_t x;
        x.name = n;
        x.at   = r_cyc;
        x.inst = inst;
        x.sel  = sel;
        x.val  = v;
        exp_q.push_back(x);
    endtask

    task automatic sec();
        r_sec = 1'b1;
        tick();
        r_sec = 1'b0;
    endtask

    task automatic do_restart();
        r_restart = 1'b1;
        tick();
        r_restart = 1'b0;
    endtask

    task automatic frame();
        r_sof = 1'b1;
        tick();
        r_sof = 1'b0;
        n_sof = n_sof + 1;
    endtask

    task automatic pix(input string n, input int x, input int y, input logic lit);
        r_px = 11'(x);
        r_py = 11'(y);
        tick();
        expect_now(n, 0, c_SEL_DR, {11'd0, lit});
        expect_now({n, "_rgb"}, 0, c_SEL_RGB, lit ? 12'h0FF : 12'h000);
        r_px = 11'd0;
        r_py = 11'd0;
    endtask

    logic r_exp_blink_lit;

    initial begin
`ifdef HUD_TIMER_BLINK_EN
        r_exp_blink_lit = 1'b0;
`else
        r_exp_blink_lit = 1'b1;
`endif
        repeat (3) tick();
        check_now("reset_bcd_direct", w_bcd1, 12'h180);
        check_now("reset_tu_direct", {11'd0, w_tu1}, 12'h000);
        check_now("reset_dr_direct", {11'd0, w_dr1}, 12'h000);
        r_resetN = 1'b1;
        tick();
        expect_now("reset_bcd", 0, c_SEL_BCD, 12'h180);
        expect_now("reset_tu", 0, c_SEL_TU, 12'h0);
        expect_now("reset_dr", 0, c_SEL_DR, 12'h0);
        expect_now("reset_rgb", 0, c_SEL_RGB, 12'h0);
        expect_now("reset_bcd2", 1, c_SEL_BCD, 12'h002);

        repeat (5) sec();
        expect_now("idle_hold", 0, c_SEL_BCD, 12'h180);
        expect_now("idle_hold2", 1, c_SEL_BCD, 12'h002);

        do_restart();
        expect_now("restart_bcd", 0, c_SEL_BCD, 12'h180);
        for (int i = 1; i <= 81; i++) begin
            sec();
            if (i == 1) expect_now("first_dec", 0, c_SEL_BCD, 12'h179);
            if (i == 2) begin
                expect_now("dut2_zero", 1, c_SEL_BCD, 12'h000);
                expect_now("dut2_timeup", 1, c_SEL_TU, 12'h1);
                check_now("dut2_expired_direct", {11'd0, w_tu2}, 12'h001);
                check_now("dut2_zero_direct", w_bcd2, 12'h000);
            end
            if (i == 3) begin
                expect_now("dut2_no_wrap", 1, c_SEL_BCD, 12'h000);
                expect_now("dut2_timeup_hold", 1, c_SEL_TU, 12'h1);
                check_now("dut2_no_wrap_direct", w_bcd2, 12'h000);
            end
            if (i == 80) expect_now("at_100", 0, c_SEL_BCD, 12'h100);
        end
        expect_now("borrow_099", 0, c_SEL_BCD, 12'h099);
        expect_now("run_tu", 0, c_SEL_TU, 12'h0);

        r_pause = 1'b1;
        tick();
        repeat (3) sec();
        expect_now("paused_hold", 0, c_SEL_BCD, 12'h099);
        r_pause = 1'b0;
        tick();
        sec();
        expect_now("resume_dec", 0, c_SEL_BCD, 12'h098);

        repeat (48) sec();
        expect_now("at_050", 0, c_SEL_BCD, 12'h050);
        r_restart = 1'b1;
        r_sec = 1'b1;
        tick();
        r_restart = 1'b0;
        r_sec = 1'b0;
        expect_now("restart_prio", 0, c_SEL_BCD, 12'h180);
        expect_now("restart_prio2", 1, c_SEL_BCD, 12'h002);
        expect_now("restart_tu2", 1, c_SEL_TU, 12'h0);

        frame();
        pix("h1_r0c0", 16, 8, 1'b0);
        pix("h1_r0c1", 20, 8, 1'b1);
        pix("h1_c3", 28, 8, 1'b0);
        pix("right_edge", 64, 8, 1'b0);
        pix("left_edge", 15, 8, 1'b0);
        pix("above", 20, 7, 1'b0);
        pix("below", 20, 28, 1'b0);
        pix("t8_r0c0", 32, 8, 1'b1);
        pix("u0_r4c0", 48, 24, 1'b1);
        pix("u0_r3c1", 52, 20, 1'b0);

        sec();
        expect_now("mid_frame_bcd", 0, c_SEL_BCD, 12'h179);
        pix("old_u0_r3c0", 48, 20, 1'b1);
        pix("old_t8_r1c0", 32, 12, 1'b1);
        frame();
        pix("new_u9_r3c0", 48, 20, 1'b0);
        pix("new_t7_r1c0", 32, 12, 1'b0);

        r_sof = 1'b1;
        r_sec = 1'b1;
        tick();
        r_sof = 1'b0;
        r_sec = 1'b0;
        n_sof = n_sof + 1;
        expect_now("sof_dec_bcd", 0, c_SEL_BCD, 12'h178);
        pix("sof_pre_dec", 48, 20, 1'b0);

        repeat (169) sec();
        expect_now("at_009", 0, c_SEL_BCD, 12'h009);
        do frame(); while ((n_sof % 32) != 16);
        pix("blink_off_frame", 48, 8, r_exp_blink_lit);
        do frame(); while ((n_sof % 32) != 0);
        pix("blink_on_frame", 48, 8, 1'b1);

        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        if (errors == 0) $display("PASS");
        else             $display("FAIL");
        $finish;
    end

endmodule

`default_nettype wire
